// File: rtl/traffic_light_controller_pkg.sv
// Shared encodings for the junction controller: phase states and lamp patterns.
// Lamp vectors are ordered {red,yellow,green}.
package traffic_light_controller_pkg;

    typedef enum logic [2:0] {
        AR_M  = 3'd0,
        MG    = 3'd1,
        MY    = 3'd2,
        AR_S  = 3'd3,
        SG    = 3'd4,
        SY    = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase down-counter: loads duration-1 on phase entry, counts ticks down to zero.
// expired flags the last tick of the current phase.
module tl_phase_timer #(
    parameter int               CNT_W   = 5,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // Counter saturates at zero so MG can hold there while it waits for a request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (tick && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road junction sequencer with pedestrian crossing and flashing-amber maintenance mode.
// Lamps and walk are decoded from registered state only.
module traffic_light_controller
    import traffic_light_controller_pkg::*;
#(
    parameter int MAIN_GREEN_T = 10,
    parameter int SIDE_GREEN_T = 5,
    parameter int YELLOW_T     = 2,
    parameter int ALL_RED_T    = 1,
    parameter int CNT_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk,
    output logic [2:0] phase
);

    state_t           state, state_nxt;
    logic             side_pend, ped_pend, walk_act, blink;
    logic             load, expired, sg_entry, sg_exit;
    logic [CNT_W-1:0] load_val;

    function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
        case (s)
            MG:      dur_m1 = CNT_W'(MAIN_GREEN_T - 1);
            SG:      dur_m1 = CNT_W'(SIDE_GREEN_T - 1);
            MY, SY:  dur_m1 = CNT_W'(YELLOW_T - 1);
            default: dur_m1 = CNT_W'(ALL_RED_T - 1);
        endcase
    endfunction

    tl_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(ALL_RED_T - 1))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= AR_M;
        else
            state <= state_nxt;
    end

    // Flash request beats any timed transition due on the same edge.
    always_comb begin
        state_nxt = state;
        if (flash_mode)
            state_nxt = FLASH;
        else if (state == FLASH)
            state_nxt = AR_M;
        else if (tick && expired) begin
            case (state)
                AR_M:    state_nxt = MG;
                MG:      if (side_pend || ped_pend) state_nxt = MY;
                MY:      state_nxt = AR_S;
                AR_S:    state_nxt = SG;
                SG:      state_nxt = SY;
                SY:      state_nxt = AR_M;
                default: state_nxt = AR_M;
            endcase
        end
        load     = (state_nxt != state) && (state_nxt != FLASH);
        load_val = dur_m1(state_nxt);
    end

    assign sg_entry = (state == AR_S) && (state_nxt == SG);
    assign sg_exit  = (state == SG) && (state_nxt != SG);

    // Side requests are moot while side already has right of way; ped set wins over clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
            walk_act  <= 1'b0;
            blink     <= 1'b0;
        end else begin
            if (sg_entry)
                side_pend <= 1'b0;
            else if (side_req && state != SG && state != SY)
                side_pend <= 1'b1;

            if (ped_req)
                ped_pend <= 1'b1;
            else if (sg_entry)
                ped_pend <= 1'b0;

            if (sg_entry)
                walk_act <= ped_pend;
            else if (sg_exit)
                walk_act <= 1'b0;

            if (state == FLASH) begin
                if (!flash_mode)
                    blink <= 1'b0;
                else if (tick)
                    blink <= ~blink;
            end
        end
    end

    always_comb begin
        main_lights = LAMP_RED;
        side_lights = LAMP_RED;
        case (state)
            MG:    main_lights = LAMP_GRN;
            MY:    main_lights = LAMP_YEL;
            SG:    side_lights = LAMP_GRN;
            SY:    side_lights = LAMP_YEL;
            FLASH: begin
                main_lights = blink ? LAMP_YEL : LAMP_OFF;
                side_lights = blink ? LAMP_RED : LAMP_OFF;
            end
            default: ;
        endcase
    end

    assign walk  = walk_act && (state == SG);
    assign phase = state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: stimulus pushes reference-model expectations, monitor pops and compares.
// Reference model tracks phase and ticks elapsed, driven by the junction's rules.
module tb_traffic_light_controller;

    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0;
    logic       side_req = 1'b0, ped_req = 1'b0, flash_mode = 1'b0;
    logic [2:0] main_lights, side_lights, phase;
    logic       walk;

    always #5 clk = ~clk;

    traffic_light_controller dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .side_req    (side_req),
        .ped_req     (ped_req),
        .flash_mode  (flash_mode),
        .main_lights (main_lights),
        .side_lights (side_lights),
        .walk        (walk),
        .phase       (phase)
    );

    typedef struct packed {
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic [2:0] p;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0;

    // Phase numbers: 0 AR_M, 1 MG, 2 MY, 3 AR_S, 4 SG, 5 SY, 6 FLASH
    int   dur[7]  = '{1, 10, 2, 1, 5, 2, 1};
    int   succ[7] = '{1, 2, 3, 4, 5, 0, 0};
    int   m_ph, m_el;
    bit   m_sp, m_pp, m_wa, m_bl;

    function automatic exp_t model_out();
        exp_t e;
        e.m = 3'b100;
        e.s = 3'b100;
        case (m_ph)
            1: e.m = 3'b001;
            2: e.m = 3'b010;
            4: e.s = 3'b001;
            5: e.s = 3'b010;
            6: begin
                e.m = m_bl ? 3'b010 : 3'b000;
                e.s = m_bl ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
        e.w = m_wa && (m_ph == 4);
        e.p = 3'(m_ph);
        return e;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_el = 0;
        m_sp = 0; m_pp = 0; m_wa = 0; m_bl = 0;
    endtask

    task automatic model_step(input bit t, input bit sr, input bit pr, input bit fm);
        int nph = m_ph, nel = m_el;
        bit nbl = m_bl, sg;
        if (fm) begin
            nph = 6;
            if (m_ph == 6 && t) nbl = !m_bl;
        end else if (m_ph == 6) begin
            nph = 0; nel = 0; nbl = 0;
        end else if (t) begin
            if (m_el + 1 < dur[m_ph]) nel = m_el + 1;
            else if (m_ph == 1 && !(m_sp || m_pp)) nel = m_el;
            else begin nph = succ[m_ph]; nel = 0; end
        end
        sg = (m_ph == 3) && (nph == 4);
        if (sg) m_wa = m_pp;
        else if (m_ph == 4 && nph != 4) m_wa = 0;
        if (sg) m_sp = 0;
        else if (sr && m_ph != 4 && m_ph != 5) m_sp = 1;
        if (pr) m_pp = 1;
        else if (sg) m_pp = 0;
        m_ph = nph; m_el = nel; m_bl = nbl;
    endtask

    task automatic step(input bit sr, input bit pr, input bit fm, input bit rst);
        @(negedge clk);
        tick = (cyc % 3 == 0);
        cyc++;
        side_req = sr; ped_req = pr; flash_mode = fm; reset = rst;
        if (rst) model_reset();
        else model_step(tick, sr, pr, fm);
        q.push_back(model_out());
    endtask

    task automatic run(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic run_until(input int ph, input int maxc);
        int k = 0;
        while (m_ph != ph && k < maxc) begin
            step(0, 0, 0, 0);
            k++;
        end
        if (m_ph != ph) begin
            checks++; errors++;
            $display("FAIL wait_phase: still in phase %0d, required %0d within %0d clks", m_ph, ph, maxc);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        q.push_back(model_out());
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
    endtask

    // Monitor: compares every pending expectation shortly after each clk or reset edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (main_lights !== e.m || side_lights !== e.s || walk !== e.w || phase !== e.p) begin
                    errors++;
                    $display("FAIL lamps @%0t: got main=%b side=%b walk=%b phase=%0d, required main=%b side=%b walk=%b phase=%0d",
                             $time, main_lights, side_lights, walk, phase, e.m, e.s, e.w, e.p);
                end
            end
        end
    end

    initial begin
        bit fm;
        model_reset();
        repeat (3) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // idle: all-red then main green held
        run(120);

        // side request early in MG
        step(1, 0, 0, 0);
        run(90);

        // late side request after MG has timed out
        run(75);
        step(1, 0, 0, 0);
        run(60);

        // pedestrian, then a second press during SG
        step(0, 1, 0, 0);
        run_until(4, 200);
        run(3);
        step(0, 1, 0, 0);
        run(90);

        // flash asserted mid-SG on a tick edge
        step(1, 0, 0, 0);
        run_until(4, 200);
        run(4);
        while (cyc % 3 != 0) step(0, 0, 0, 0);
        repeat (18) step(0, 0, 1, 0);
        run(20);

        // async reset during SY with requests pending
        step(1, 1, 0, 0);
        run_until(5, 200);
        step(0, 1, 0, 0);
        async_reset();
        run(120);

        // randomized traffic with occasional flash episodes
        fm = 0;
        repeat (700) begin
            if ($urandom_range(0, 59) == 0) fm = !fm;
            step($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0, fm, 0);
        end
        run(30);

        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
